// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks on the PC/FPGA link.
//   uart_state_t        : transmitter/receiver frame state encoding
//   CLKS_PER_BIT_115200 : system clocks per bit at 125 MHz / 115200 baud
//   START_BIT/STOP_BIT  : line levels of the 8N1 framing bits
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } uart_state_t;

    localparam int   CLKS_PER_BIT_115200 = 1085;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Free-running bit-period counter that produces a clock-enable tick.
// tick is high for one cycle every CLKS_PER_BIT cycles; the first tick after
// restart arrives CLKS_PER_BIT cycles after the restart edge, so a bit that
// starts on the restart edge lasts exactly one bit period.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   restart in  zero the counter on this edge (phase realignment)
//   tick    out one-cycle pulse marking the last cycle of a bit period
// ----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (restart || count == LAST_CNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST_CNT);

endmodule

// File: rtl/uart_word_tx.sv
// ----------------------------------------------------------------------------
// uart_word_tx
// UART transmitter that sends one WORD_BYTES-byte word per valid/ready
// handshake, most significant byte first, 8N1 framing, LSB first per byte.
// Optional feature macro: UART_TERM_BYTE_EN -- when defined, a trailing
// TERM_BYTE frame follows the last data byte of every word.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high reset
//   tx_data  in  word to send, sampled only on accept
//   tx_valid in  tx_data valid
//   tx_ready out block can accept a word (IDLE or DONE)
//   tx_out   out registered serial line, idles high
//   tx_busy  out frame in progress
//   tx_done  out one-cycle pulse after the final stop bit
// ----------------------------------------------------------------------------
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int         WORD_BYTES   = 2,
    parameter logic [7:0] TERM_BYTE    = 8'h0A
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_out,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int BYTE_IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(WORD_BYTES - 1);

`ifdef UART_TERM_BYTE_EN
    localparam bit HAS_TERM = 1'b1;
`else
    localparam bit HAS_TERM = 1'b0;
`endif

    uart_state_t             state,    state_n;
    logic [WORD_W-1:0]       shift_sr, shift_sr_n;
    logic [2:0]              bit_idx,  bit_idx_n;
    logic [BYTE_IDX_W-1:0]   byte_idx, byte_idx_n;
    logic                    term_sent, term_sent_n;
    logic                    tx_out_n;
    logic                    restart;
    logic                    tick;
    logic [7:0]              cur_byte;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // The byte on the wire is always the top byte of the shift register;
    // moving to the next byte shifts the register up by eight.
    assign cur_byte = shift_sr[WORD_W-1 -: 8];

    // Next-state logic. tx_out is computed here and registered so every
    // line transition lands on the same edge as the state change that
    // causes it, which puts the start bit on the wire at the accept edge.
    always_comb begin
        state_n     = state;
        shift_sr_n  = shift_sr;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        term_sent_n = term_sent;
        tx_out_n    = tx_out;
        restart     = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (tx_valid) begin
                    state_n     = START;
                    shift_sr_n  = tx_data;
                    bit_idx_n   = 3'd0;
                    byte_idx_n  = '0;
                    term_sent_n = 1'b0;
                    tx_out_n    = START_BIT;
                    restart     = 1'b1;
                end else begin
                    state_n  = IDLE;
                    tx_out_n = STOP_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    bit_idx_n = 3'd0;
                    tx_out_n  = cur_byte[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_n  = STOP;
                        tx_out_n = STOP_BIT;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_out_n  = cur_byte[bit_idx_n];
                    end
                end
            end
            STOP: begin
                // Next byte starts with no idle gap; the byte index stops at
                // the last data byte, the terminator is tracked separately.
                if (tick) begin
                    if (byte_idx != LAST_BYTE && !term_sent) begin
                        state_n    = START;
                        byte_idx_n = byte_idx + 1'b1;
                        shift_sr_n = shift_sr << 8;
                        tx_out_n   = START_BIT;
                    end else if (HAS_TERM && !term_sent) begin
                        state_n                   = START;
                        term_sent_n               = 1'b1;
                        shift_sr_n[WORD_W-1 -: 8] = TERM_BYTE;
                        tx_out_n                  = START_BIT;
                    end else begin
                        state_n  = DONE;
                        tx_out_n = STOP_BIT;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                tx_out_n = STOP_BIT;
            end
        endcase
    end

    // State registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_sr  <= '0;
            bit_idx   <= 3'd0;
            byte_idx  <= '0;
            term_sent <= 1'b0;
            tx_out    <= STOP_BIT;
        end else begin
            state     <= state_n;
            shift_sr  <= shift_sr_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            term_sent <= term_sent_n;
            tx_out    <= tx_out_n;
        end
    end

    assign tx_ready = (state == IDLE) || (state == DONE);
    assign tx_busy  = !tx_ready;
    assign tx_done  = (state == DONE);

endmodule

// File: tb/tb_uart_word_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_word_tx
// Self-checking bench for uart_word_tx with CLKS_PER_BIT=4, WORD_BYTES=2.
// Expected bytes are queued when a word is driven; a line monitor decodes
// 8N1 bytes off tx_out and compares them against the queue.
// ----------------------------------------------------------------------------
module tb_uart_word_tx;

    localparam int CPB = 4;
    localparam int WB  = 2;
    localparam logic [7:0] TERM = 8'h0A;
`ifdef UART_TERM_BYTE_EN
    localparam int FRAME_BYTES = WB + 1;
`else
    localparam int FRAME_BYTES = WB;
`endif
    localparam int FRAME_CYCLES = 10 * CPB * FRAME_BYTES;

    logic          clk;
    logic          reset;
    logic [15:0]   tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_out;
    logic          tx_busy;
    logic          tx_done;

    int            errors = 0;
    int            checks = 0;
    logic [7:0]    exp_q[$];

    uart_word_tx #(
        .CLKS_PER_BIT (CPB),
        .WORD_BYTES   (WB),
        .TERM_BYTE    (TERM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the bytes a word should produce on the line, in wire order.
    task automatic push_word(input logic [15:0] data);
        for (int i = 0; i < WB; i++) begin
            exp_q.push_back(data[8*(WB-1-i) +: 8]);
        end
`ifdef UART_TERM_BYTE_EN
        exp_q.push_back(TERM);
`endif
    endtask

    // Decode one byte whose start bit was seen low at the current negedge.
    task automatic decode_byte(output bit aborted, output logic [7:0] b,
                               output bit width_ok, output bit stop_ok);
        aborted  = 1'b0;
        width_ok = 1'b1;
        stop_ok  = 1'b1;
        b        = 8'h00;
        for (int c = 1; c < CPB; c++) begin
            @(negedge clk);
            if (reset) begin aborted = 1'b1; return; end
            if (tx_out !== 1'b0) width_ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (reset) begin aborted = 1'b1; return; end
                if (c == 0) b[i] = tx_out;
                else if (tx_out !== b[i]) width_ok = 1'b0;
            end
        end
        for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (reset) begin aborted = 1'b1; return; end
            if (tx_out !== 1'b1) stop_ok = 1'b0;
        end
    endtask

    // Line monitor: finds falling edges on tx_out and scores each byte.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic [7:0] exp_b;
        bit         aborted, width_ok, stop_ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx_out === 1'b0) begin
                decode_byte(aborted, b, width_ok, stop_ok);
                if (aborted) begin
                    prev = 1'b1;
                end else begin
                    checks++;
                    if (!width_ok) begin
                        errors++;
                        $display("[TB] FAIL bit_width: a bit was not %0d cycles wide (byte 0x%02h)", CPB, b);
                    end
                    checks++;
                    if (!stop_ok) begin
                        errors++;
                        $display("[TB] FAIL stop_bit: stop bit not high for %0d cycles (byte 0x%02h)", CPB, b);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL byte_value: got 0x%02h, expected no byte", b);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (b !== exp_b) begin
                            errors++;
                            $display("[TB] FAIL byte_value: got 0x%02h, expected 0x%02h", b, exp_b);
                        end
                    end
                    prev = tx_out;
                end
            end else begin
                prev = tx_out;
            end
        end
    end

    // Present a word, wait for the accept edge, return at the first start cycle.
    task automatic send_word(input logic [15:0] data);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tx_data  = data;
        tx_valid = 1'b1;
        push_word(data);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
    endtask

    // Count negedges until tx_done, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (tx_done !== 1'b1 && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int done_seen = 0;
        int low_seen  = 0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 16'h0000;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: out=%b ready=%b busy=%b done=%b, expected 1 1 0 0",
                     tx_out, tx_ready, tx_busy, tx_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_done !== 1'b0) done_seen++;
            if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) low_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("[TB] FAIL idle_done: tx_done high %0d cycles, expected 0", done_seen);
        end
        checks++;
        if (low_seen != 0) begin
            errors++;
            $display("[TB] FAIL idle_state: %0d cycles off idle, expected 0", low_seen);
        end
    endtask

    task automatic test_single_word();
        int cyc;
        int extra = 0;
        send_word(16'hA53C);
        checks++;
        if (tx_out !== 1'b0 || tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_latency: out=%b ready=%b busy=%b, expected 0 0 1",
                     tx_out, tx_ready, tx_busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != FRAME_CYCLES) begin
            errors++;
            $display("[TB] FAIL done_latency: %0d cycles, expected %0d", cyc, FRAME_CYCLES);
        end
        checks++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_cycle: out=%b ready=%b busy=%b, expected 1 1 0",
                     tx_out, tx_ready, tx_busy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_done !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL done_once: %0d extra tx_done cycles, expected 0", extra);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL single_drain: %0d bytes not seen, expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        tx_data  = 16'h0001;
        tx_valid = 1'b1;
        push_word(16'h0001);
        push_word(16'hFF00);
        @(negedge clk);
        tx_data = 16'hFF00;
        checks++;
        if (tx_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_start1: out=%b, expected 0", tx_out);
        end
        wait_done(c1);
        checks++;
        if (c1 != FRAME_CYCLES) begin
            errors++;
            $display("[TB] FAIL b2b_len1: %0d cycles, expected %0d", c1, FRAME_CYCLES);
        end
        checks++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_gap: out=%b ready=%b in done cycle, expected 1 1", tx_out, tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx_out !== 1'b0 || tx_done !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_start2: out=%b done=%b busy=%b, expected 0 0 1",
                     tx_out, tx_done, tx_busy);
        end
        wait_done(c2);
        checks++;
        if (c2 != FRAME_CYCLES) begin
            errors++;
            $display("[TB] FAIL b2b_len2: %0d cycles, expected %0d", c2, FRAME_CYCLES);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: %0d bytes not seen, expected 0", exp_q.size());
        end
    endtask

    task automatic test_ignore_busy();
        int cyc = 0;
        int ready_high = 0;
        send_word(16'h5AC3);
        while (tx_done !== 1'b1 && cyc < 400) begin
            if (tx_ready !== 1'b0) ready_high++;
            if (cyc < 70) begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = 16'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (ready_high != 0) begin
            errors++;
            $display("[TB] FAIL busy_ready: tx_ready high %0d cycles mid-frame, expected 0", ready_high);
        end
        checks++;
        if (cyc != FRAME_CYCLES) begin
            errors++;
            $display("[TB] FAIL busy_len: %0d cycles, expected %0d", cyc, FRAME_CYCLES);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || tx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_drain: %0d bytes left busy=%b, expected 0 0", exp_q.size(), tx_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_seen = 0;
        int cyc;
        send_word(16'hC3A7);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: out=%b done=%b busy=%b, expected 1 0 0",
                     tx_out, tx_done, tx_busy);
        end
        checks++;
        if (exp_q.size() != FRAME_BYTES - 1) begin
            errors++;
            $display("[TB] FAIL mid_first_byte: %0d bytes pending, expected %0d", exp_q.size(), FRAME_BYTES - 1);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_out !== 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("[TB] FAIL mid_quiet: %0d non-idle cycles after reset, expected 0", done_seen);
        end
        send_word(16'h1234);
        wait_done(cyc);
        checks++;
        if (cyc != FRAME_CYCLES) begin
            errors++;
            $display("[TB] FAIL mid_recover_len: %0d cycles, expected %0d", cyc, FRAME_CYCLES);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_recover_drain: %0d bytes not seen, expected 0", exp_q.size());
        end
    endtask

`ifdef UART_TERM_BYTE_EN
    task automatic test_term_byte();
        int cyc;
        send_word(16'hBEEF);
        wait_done(cyc);
        checks++;
        if (cyc != 120) begin
            errors++;
            $display("[TB] FAIL term_len: %0d cycles, expected 120", cyc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL term_drain: %0d bytes not seen, expected 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        $display("[TB] uart_word_tx bench, frame bytes=%0d", FRAME_BYTES);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
`ifdef UART_TERM_BYTE_EN
        test_term_byte();
`endif
        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
